// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide,
// WIDTH RUN cycles plus one FIX cycle for sign correction and result write.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic             is_div, sgn_q, sgn_r, dz_flag;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;

    logic             is_idle, a_neg, b_neg, div_zero_req;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign is_idle      = (state == IDLE);
    assign busy         = !is_idle;
    assign stall        = hilo_rd & (busy | (start & is_idle));
    assign div_zero_req = op[1] && (b == '0);

    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    assign a_abs = a_neg ? -a : a;
    assign b_abs = b_neg ? -b : b;

    // Multiply: acc_hi is the running partial product, acc_lo shifts out multiplier bits.
    assign mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    assign prod     = {acc_hi, acc_lo};
    assign prod_neg = -prod;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = div_zero_req ? FIX : RUN;
            RUN:     if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            is_div      <= 1'b0;
            sgn_q       <= 1'b0;
            sgn_r       <= 1'b0;
            dz_flag     <= 1'b0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    is_div  <= op[1];
                    cnt     <= '0;
                    opnd    <= op[1] ? b_abs : a_abs;
                    sgn_q   <= a_neg ^ b_neg;
                    sgn_r   <= a_neg;
                    dz_flag <= 1'b0;
                    if (div_zero_req) begin
                        // Preload the architected divide-by-zero result; FIX writes it unchanged.
                        acc_hi  <= a;
                        acc_lo  <= '1;
                        sgn_q   <= 1'b0;
                        sgn_r   <= 1'b0;
                        dz_flag <= 1'b1;
                    end else begin
                        acc_hi <= '0;
                        acc_lo <= op[1] ? a_abs : b_abs;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (!is_div) begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end else if (!div_diff[WIDTH]) begin
                        acc_hi <= div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= dz_flag;
                    if (!is_div) begin
                        {hi, lo} <= sgn_q ? prod_neg : prod;
                    end else begin
                        lo <= sgn_q ? -acc_lo : acc_lo;
                        hi <= sgn_r ? -acc_hi : acc_hi;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
